// File: rtl/tx_pll_pkg.sv
// Shared types and constants for the LVDS TX PLL supervisor.
package tx_pll_pkg;

  typedef enum logic [2:0] {
    StRstHold,
    StWaitLock,
    StRun,
    StDrpWr,
    StDrpWait,
    StFault
  } pll_state_e;

  localparam logic [7:0] DRP_ADDR_FBDIV = 8'h10;
  localparam logic [7:0] DRP_ADDR_C0DIV = 8'h20;
  localparam logic [7:0] DRP_ADDR_C2DIV = 8'h28;

  // Mode tables are packed with mode 0 in the least significant byte.
  function automatic logic [7:0] mode_byte(input logic [127:0] tbl, input int unsigned idx);
    return tbl[idx*8 +: 8];
  endfunction

endpackage

// File: rtl/tx_pll_lock_filter.sv
// Lock synchroniser plus consecutive-lock qualification counter.
module tx_pll_lock_filter #(
  parameter int unsigned LOCK_STABLE = 256
) (
  input  logic refclk,
  input  logic reset,
  input  logic pll_lock,
  input  logic count_en,
  output logic lock_stable,
  output logic lock_lost
);

  localparam int unsigned CW = $clog2(LOCK_STABLE + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge refclk) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], pll_lock};
      if (!count_en || !sync_q[1]) begin
        cnt_q <= '0;
      end else if (cnt_q != CW'(LOCK_STABLE)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign lock_stable = (cnt_q == CW'(LOCK_STABLE));
  assign lock_lost   = ~sync_q[1];

endmodule

// File: rtl/tx_pll_mgr.sv
// TX PLL supervisor: reset sequencing, lock qualification with retries and
// run-time mode switching through three DRP divider writes.
module tx_pll_mgr #(
  parameter int unsigned              NUM_MODES    = 4,
  parameter int unsigned              MODE_W       = $clog2(NUM_MODES),
  parameter logic [NUM_MODES*8-1:0]   MODE_FBDIV   = {8'd60, 8'd45, 8'd40, 8'd50},
  parameter logic [NUM_MODES*8-1:0]   MODE_C0DIV   = {8'd4, 8'd5, 8'd10, 8'd7},
  parameter logic [NUM_MODES*8-1:0]   MODE_C2DIV   = {8'd4, 8'd5, 8'd10, 8'd7},
  parameter int unsigned              RST_CYCLES   = 16,
  parameter int unsigned              LOCK_STABLE  = 256,
  parameter int unsigned              LOCK_TIMEOUT = 65535,
  parameter int unsigned              MAX_RETRY    = 3,
  parameter int unsigned              DRP_TIMEOUT  = 64
) (
  input  logic              refclk,
  input  logic              reset,
  input  logic [MODE_W-1:0] mode_sel,
  input  logic              mode_req,
  input  logic              pll_lock,
  output logic              pll_reset,
  output logic              drp_sel,
  output logic              drp_wr,
  output logic [7:0]        drp_addr,
  output logic [7:0]        drp_wdata,
  input  logic              drp_rdy,
  input  logic              drp_err,
  output logic              ready,
  output logic              busy,
  output logic              err,
  output logic [MODE_W-1:0] cur_mode
);
  import tx_pll_pkg::*;

  localparam int unsigned RW = $clog2(MAX_RETRY + 1);

  pll_state_e        state_q;
  logic [31:0]       cnt_q;
  logic [RW-1:0]     retry_q;
  logic [1:0]        wr_idx_q;
  logic [MODE_W-1:0] pend_q, cur_mode_q;
  logic              err_q, pll_reset_q, ready_q, busy_q, drp_sel_q, drp_wr_q;
  logic [7:0]        drp_addr_q, drp_wdata_q;
  logic              lock_stable, lock_lost, mode_valid;

  tx_pll_lock_filter #(
    .LOCK_STABLE (LOCK_STABLE)
  ) u_lock_filter (
    .refclk      (refclk),
    .reset       (reset),
    .pll_lock    (pll_lock),
    .count_en    (state_q == StWaitLock),
    .lock_stable (lock_stable),
    .lock_lost   (lock_lost)
  );

  assign mode_valid = (32'(mode_sel) < NUM_MODES);

  always_ff @(posedge refclk) begin
    if (reset) begin
      state_q     <= StRstHold;
      cnt_q       <= '0;
      retry_q     <= '0;
      wr_idx_q    <= '0;
      pend_q      <= '0;
      cur_mode_q  <= '0;
      err_q       <= 1'b0;
      pll_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
      drp_sel_q   <= 1'b0;
      drp_wr_q    <= 1'b0;
      drp_addr_q  <= '0;
      drp_wdata_q <= '0;
    end else begin
      drp_sel_q <= 1'b0;
      drp_wr_q  <= 1'b0;
      unique case (state_q)
        StRstHold: begin
          if (cnt_q == 32'(RST_CYCLES - 1)) begin
            state_q     <= StWaitLock;
            cnt_q       <= '0;
            pll_reset_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StWaitLock: begin
          if (lock_stable) begin
            state_q <= StRun;
            retry_q <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else if (cnt_q == 32'(LOCK_TIMEOUT - 1)) begin
            cnt_q       <= '0;
            pll_reset_q <= 1'b1;
            if (retry_q < RW'(MAX_RETRY)) begin
              retry_q <= retry_q + 1'b1;
              state_q <= StRstHold;
            end else begin
              err_q   <= 1'b1;
              state_q <= StFault;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StRun: begin
          // Lock loss outranks a coincident mode request.
          if (lock_lost) begin
            state_q     <= StRstHold;
            cnt_q       <= '0;
            pll_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
          end else if (mode_req && !mode_valid) begin
            err_q <= 1'b1;
          end else if (mode_req && mode_sel != cur_mode_q) begin
            state_q     <= StDrpWr;
            pend_q      <= mode_sel;
            wr_idx_q    <= '0;
            pll_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        StDrpWr: begin
          drp_sel_q <= 1'b1;
          drp_wr_q  <= 1'b1;
          state_q   <= StDrpWait;
          cnt_q     <= '0;
          unique case (wr_idx_q)
            2'd0: begin
              drp_addr_q  <= DRP_ADDR_FBDIV;
              drp_wdata_q <= mode_byte(128'(MODE_FBDIV), 32'(pend_q));
            end
            2'd1: begin
              drp_addr_q  <= DRP_ADDR_C0DIV;
              drp_wdata_q <= mode_byte(128'(MODE_C0DIV), 32'(pend_q));
            end
            default: begin
              drp_addr_q  <= DRP_ADDR_C2DIV;
              drp_wdata_q <= mode_byte(128'(MODE_C2DIV), 32'(pend_q));
            end
          endcase
        end
        StDrpWait: begin
          if ((drp_rdy && drp_err) || (!drp_rdy && cnt_q == 32'(DRP_TIMEOUT - 1))) begin
            err_q   <= 1'b1;
            state_q <= StFault;
            busy_q  <= 1'b0;
          end else if (drp_rdy && wr_idx_q == 2'd2) begin
            cur_mode_q <= pend_q;
            state_q    <= StRstHold;
            cnt_q      <= '0;
          end else if (drp_rdy) begin
            wr_idx_q <= wr_idx_q + 2'd1;
            state_q  <= StDrpWr;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StFault: begin
          if (mode_req && mode_valid) begin
            err_q    <= 1'b0;
            retry_q  <= '0;
            state_q  <= StDrpWr;
            pend_q   <= mode_sel;
            wr_idx_q <= '0;
            busy_q   <= 1'b1;
          end else if (mode_req) begin
            err_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= StRstHold;
          cnt_q       <= '0;
          pll_reset_q <= 1'b1;
          ready_q     <= 1'b0;
          busy_q      <= 1'b1;
        end
      endcase
    end
  end

  assign pll_reset = pll_reset_q;
  assign drp_sel   = drp_sel_q;
  assign drp_wr    = drp_wr_q;
  assign drp_addr  = drp_addr_q;
  assign drp_wdata = drp_wdata_q;
  assign ready     = ready_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign cur_mode  = cur_mode_q;

endmodule

// File: tb/tb_tx_pll_mgr.sv
// Directed bench for tx_pll_mgr with a DRP write scoreboard and responder.
module tb_tx_pll_mgr;

  localparam int unsigned NM  = 3;
  localparam int unsigned MW  = 2;
  localparam int unsigned LS  = 32;
  localparam int unsigned LT  = 200;
  localparam int unsigned RC  = 16;
  localparam int unsigned DT  = 64;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } drp_exp_t;

  logic          refclk = 1'b0;
  logic          reset, mode_req, pll_lock, drp_rdy, drp_err;
  logic [MW-1:0] mode_sel;
  logic          pll_reset, drp_sel, drp_wr, ready, busy, err;
  logic [7:0]    drp_addr, drp_wdata;
  logic [MW-1:0] cur_mode;

  int n_cmp = 0;
  int n_err = 0;
  int rdy_delay = 0;
  int withhold_at = 0;
  int wr_cnt = 0;
  drp_exp_t sb[$];

  // Expected divider tables, indexed by mode.
  int       fb_t [3] = '{50, 40, 45};
  int       c0_t [3] = '{7, 10, 5};
  int       c2_t [3] = '{7, 20, 9};
  logic [7:0] addr_t [3] = '{8'h10, 8'h20, 8'h28};

  tx_pll_mgr #(
    .NUM_MODES    (NM),
    .MODE_W       (MW),
    .MODE_FBDIV   ({8'd45, 8'd40, 8'd50}),
    .MODE_C0DIV   ({8'd5, 8'd10, 8'd7}),
    .MODE_C2DIV   ({8'd9, 8'd20, 8'd7}),
    .RST_CYCLES   (RC),
    .LOCK_STABLE  (LS),
    .LOCK_TIMEOUT (LT),
    .MAX_RETRY    (3),
    .DRP_TIMEOUT  (DT)
  ) dut (
    .refclk    (refclk),
    .reset     (reset),
    .mode_sel  (mode_sel),
    .mode_req  (mode_req),
    .pll_lock  (pll_lock),
    .pll_reset (pll_reset),
    .drp_sel   (drp_sel),
    .drp_wr    (drp_wr),
    .drp_addr  (drp_addr),
    .drp_wdata (drp_wdata),
    .drp_rdy   (drp_rdy),
    .drp_err   (drp_err),
    .ready     (ready),
    .busy      (busy),
    .err       (err),
    .cur_mode  (cur_mode)
  );

  always #20 refclk = ~refclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic push_mode(input int m, input int n);
    for (int w = 0; w < n; w++) begin
      int d;
      d = (w == 0) ? fb_t[m] : (w == 1) ? c0_t[m] : c2_t[m];
      sb.push_back({addr_t[w], 8'(d)});
    end
  endtask

  task automatic wait_ready(input string tag, input int max);
    int i = 0;
    while (ready !== 1'b1 && i < max) begin
      tick(1);
      i++;
    end
    check(tag, 32'(ready), 1);
  endtask

  task automatic wait_mode(input string tag, input logic [MW-1:0] m, input int max);
    int i = 0;
    while (cur_mode !== m && i < max) begin
      tick(1);
      i++;
    end
    check(tag, 32'(cur_mode), 32'(m));
  endtask

  task automatic wait_strobes(input string tag, input int n, input int max);
    int seen = 0;
    int i = 0;
    while (seen < n && i < max) begin
      tick(1);
      i++;
      if (drp_wr === 1'b1) seen++;
    end
    check(tag, 32'(seen), 32'(n));
  endtask

  task automatic request(input logic [MW-1:0] m);
    mode_sel = m;
    mode_req = 1'b1;
    tick(1);
    mode_req = 1'b0;
  endtask

  // DRP responder: answers each strobe after rdy_delay cycles unless told to withhold.
  initial begin : drp_responder
    drp_rdy = 1'b0;
    forever begin
      @(negedge refclk);
      if (drp_wr === 1'b1) begin
        wr_cnt++;
        if (wr_cnt != withhold_at) begin
          repeat (rdy_delay) @(negedge refclk);
          drp_rdy = 1'b1;
          @(negedge refclk);
          drp_rdy = 1'b0;
        end
      end
    end
  end

  initial begin : drp_monitor
    logic     prev_wr;
    drp_exp_t e;
    prev_wr = 1'b0;
    forever begin
      @(negedge refclk);
      if (drp_wr === 1'b1) begin
        check("drp_expected", 32'(sb.size() != 0), 1);
        check("drp_gap", 32'(prev_wr), 0);
        check("drp_sel", 32'(drp_sel), 1);
        check("drp_pll_reset", 32'(pll_reset), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("drp_addr_data", 32'({drp_addr, drp_wdata}), 32'(e));
        end
      end
      prev_wr = drp_wr;
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation did not finish, n_err %0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pll_lock = 1'b0; mode_req = 1'b0; mode_sel = '0; drp_err = 1'b0;
    tick(3);
    check("rst_pll_reset", 32'(pll_reset), 1);
    check("rst_busy", 32'(busy), 1);
    check("rst_ready", 32'(ready), 0);
    check("rst_err", 32'(err), 0);
    check("rst_cur_mode", 32'(cur_mode), 0);
    check("rst_drp_strobe", 32'({drp_sel, drp_wr}), 0);
    check("rst_drp_bus", 32'({drp_addr, drp_wdata}), 0);

    // Power-up: reset pulse length, then lock at cycle 40.
    reset = 1'b0;
    tick(RC - 1);
    check("hold_pll_reset", 32'(pll_reset), 1);
    tick(1);
    check("release_pll_reset", 32'(pll_reset), 0);
    check("wait_busy", 32'(busy), 1);
    tick(40 - RC);
    pll_lock = 1'b1;
    tick(LS + 2);
    check("lock_early_ready", 32'(ready), 0);
    tick(1);
    check("lock_ready", 32'(ready), 1);
    check("run_busy", 32'(busy), 0);

    // Lock loss drops ready within three cycles.
    pll_lock = 1'b0;
    tick(3);
    check("loss_ready", 32'(ready), 0);
    check("loss_pll_reset", 32'(pll_reset), 1);

    // One-cycle glitch restarts the stable count.
    tick(RC + 4);
    pll_lock = 1'b1;
    tick(10);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(LS + 2);
    check("glitch_early_ready", 32'(ready), 0);
    tick(1);
    check("glitch_ready", 32'(ready), 1);

    // Mode 2 switch, rdy returned in the strobe cycle.
    rdy_delay = 0;
    push_mode(2, 3);
    request(2'd2);
    check("drp_enter_busy", 32'(busy), 1);
    check("drp_enter_pll_reset", 32'(pll_reset), 1);
    check("drp_enter_ready", 32'(ready), 0);
    wait_mode("mode2_cur_mode", 2'd2, 40);
    check("mode2_pll_reset", 32'(pll_reset), 1);
    wait_ready("mode2_relock", 120);
    check("mode2_sb_empty", 32'(sb.size()), 0);

    // Second write never answered: DRP timeout.
    rdy_delay = 1;
    withhold_at = wr_cnt + 2;
    push_mode(1, 2);
    request(2'd1);
    wait_strobes("tmo_strobes", 2, 40);
    tick(DT - 1);
    check("tmo_err_before", 32'(err), 0);
    tick(1);
    check("tmo_err", 32'(err), 1);
    check("tmo_busy", 32'(busy), 0);
    check("tmo_pll_reset", 32'(pll_reset), 1);
    check("tmo_ready", 32'(ready), 0);
    check("tmo_cur_mode", 32'(cur_mode), 2);

    // Recovery from FAULT into mode 1.
    rdy_delay = 3;
    withhold_at = 0;
    push_mode(1, 3);
    request(2'd1);
    check("recover_err", 32'(err), 0);
    check("recover_busy", 32'(busy), 1);
    wait_mode("mode1_cur_mode", 2'd1, 60);
    wait_ready("mode1_relock", 120);
    check("mode1_sb_empty", 32'(sb.size()), 0);

    // Same mode is ignored; out-of-range mode sets err but stays in RUN.
    request(2'd1);
    tick(2);
    check("same_busy", 32'(busy), 0);
    check("same_ready", 32'(ready), 1);
    request(2'd3);
    check("invalid_err", 32'(err), 1);
    tick(2);
    check("invalid_ready", 32'(ready), 1);
    check("invalid_cur_mode", 32'(cur_mode), 1);

    // Reset in DRP_WAIT aborts at once.
    withhold_at = wr_cnt + 1;
    push_mode(2, 1);
    request(2'd2);
    wait_strobes("abort_strobe", 1, 10);
    tick(2);
    reset = 1'b1;
    pll_lock = 1'b0;
    tick(1);
    reset = 1'b0;
    check("abort_pll_reset", 32'(pll_reset), 1);
    check("abort_drp_wr", 32'(drp_wr), 0);
    check("abort_cur_mode", 32'(cur_mode), 0);
    check("abort_err", 32'(err), 0);
    check("abort_sb_empty", 32'(sb.size()), 0);

    // No lock: three retries, fourth timeout faults.
    tick(RC + LT - 1);
    check("try1_pll_reset", 32'(pll_reset), 0);
    tick(1);
    check("retry1_pll_reset", 32'(pll_reset), 1);
    check("retry1_err", 32'(err), 0);
    tick(3 * (RC + LT) - 1);
    check("try4_err", 32'(err), 0);
    check("try4_pll_reset", 32'(pll_reset), 0);
    tick(1);
    check("fault_err", 32'(err), 1);
    check("fault_pll_reset", 32'(pll_reset), 1);
    check("fault_ready", 32'(ready), 0);
    check("fault_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
